// File: rtl/filter_dot_product_accumulator.sv
// Four-filter fixed-point dot-product accumulator.
// One activation element is multiplied against four filter elements per accepted
// cycle; after VECTOR_LENGTH accepts the four sums are scaled by FRAC_BITS,
// saturated to 16 bits and presented with a one-cycle result_valid pulse.
// Ports:
//   clock, clear_n           - rising-edge clock, async active-low reset
//   clear                    - synchronous soft clear (discards in-flight vector)
//   en, b_elements_ready     - an element is accepted when both are high
//   a_element, b0..b3_element- signed 16-bit activation / filter elements
//   result_valid             - one-cycle pulse, out0..out3 hold a new result
//   out0..out3, saturated    - saturated results and per-filter clamp flags
//   busy                     - vector partially accumulated or in the pipeline
module filter_dot_product_accumulator #(
    parameter int unsigned FRAC_BITS     = 8,
    parameter int unsigned VECTOR_LENGTH = 16
) (
    input  logic        clock,
    input  logic        clear_n,
    input  logic        clear,
    input  logic        en,
    input  logic        b_elements_ready,
    input  logic [15:0] a_element,
    input  logic [15:0] b0_element,
    input  logic [15:0] b1_element,
    input  logic [15:0] b2_element,
    input  logic [15:0] b3_element,
    output logic        result_valid,
    output logic [15:0] out0,
    output logic [15:0] out1,
    output logic [15:0] out2,
    output logic [15:0] out3,
    output logic [3:0]  saturated,
    output logic        busy
);

    localparam int unsigned DATA_W   = 16;
    localparam int unsigned PROD_W   = 32;
    localparam int unsigned ACC_W    = 36;
    localparam int unsigned NUM_FILT = 4;
    localparam int unsigned CNT_W    = (VECTOR_LENGTH > 2) ? $clog2(VECTOR_LENGTH) : 1;

    localparam logic [CNT_W-1:0]        LAST_CNT = CNT_W'(VECTOR_LENGTH - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX  = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] SAT_MIN  = ACC_W'(-32768);

    // Input views
    logic                     accept;
    logic                     last_c;
    logic signed [DATA_W-1:0] a_s;
    logic signed [DATA_W-1:0] b_vec [NUM_FILT];

    // Pipeline state
    logic [CNT_W-1:0]         cnt_q;
    logic [CNT_W-1:0]         cnt_next;
    logic                     s1_valid_q;
    logic                     s1_last_q;
    logic signed [PROD_W-1:0] prod_q [NUM_FILT];
    logic signed [ACC_W-1:0]  acc_q  [NUM_FILT];
    logic [DATA_W-1:0]        out_q  [NUM_FILT];

    // Combinational datapath
    logic signed [PROD_W-1:0] prod_c  [NUM_FILT];
    logic signed [ACC_W-1:0]  sum_c   [NUM_FILT];
    logic signed [ACC_W-1:0]  shift_c [NUM_FILT];
    logic [DATA_W-1:0]        clamp_c [NUM_FILT];
    logic [NUM_FILT-1:0]      sat_c;

    assign accept   = en & b_elements_ready;
    assign last_c   = (cnt_q == LAST_CNT);
    assign a_s      = a_element;
    assign b_vec[0] = b0_element;
    assign b_vec[1] = b1_element;
    assign b_vec[2] = b2_element;
    assign b_vec[3] = b3_element;

    assign out0 = out_q[0];
    assign out1 = out_q[1];
    assign out2 = out_q[2];
    assign out3 = out_q[3];

    // Element counter advance; wraps after the last element of a vector
    always_comb begin
        cnt_next = cnt_q;
        if (accept) begin
            cnt_next = last_c ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // Multiply, accumulate, scale and saturate
    always_comb begin
        sat_c = '0;
        for (int k = 0; k < NUM_FILT; k++) begin
            prod_c[k]  = PROD_W'(a_s) * PROD_W'(b_vec[k]);
            sum_c[k]   = acc_q[k] + ACC_W'(prod_q[k]);
            shift_c[k] = sum_c[k] >>> FRAC_BITS;
            clamp_c[k] = DATA_W'(shift_c[k]);
            if (shift_c[k] > SAT_MAX) begin
                clamp_c[k] = 16'h7FFF;
                sat_c[k]   = 1'b1;
            end else if (shift_c[k] < SAT_MIN) begin
                clamp_c[k] = 16'h8000;
                sat_c[k]   = 1'b1;
            end
        end
    end

    // Pipeline registers; soft clear drops in-flight work but keeps held outputs
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            cnt_q        <= '0;
            s1_valid_q   <= 1'b0;
            s1_last_q    <= 1'b0;
            result_valid <= 1'b0;
            saturated    <= '0;
            busy         <= 1'b0;
            for (int k = 0; k < NUM_FILT; k++) begin
                prod_q[k] <= '0;
                acc_q[k]  <= '0;
                out_q[k]  <= '0;
            end
        end else if (clear) begin
            cnt_q        <= '0;
            s1_valid_q   <= 1'b0;
            s1_last_q    <= 1'b0;
            result_valid <= 1'b0;
            busy         <= 1'b0;
            for (int k = 0; k < NUM_FILT; k++) begin
                acc_q[k] <= '0;
            end
        end else begin
            cnt_q        <= cnt_next;
            s1_valid_q   <= accept;
            s1_last_q    <= accept & last_c;
            result_valid <= s1_valid_q & s1_last_q;
            busy         <= (cnt_next != '0) | accept;
            if (accept) begin
                for (int k = 0; k < NUM_FILT; k++) begin
                    prod_q[k] <= prod_c[k];
                end
            end
            if (s1_valid_q) begin
                for (int k = 0; k < NUM_FILT; k++) begin
                    acc_q[k] <= s1_last_q ? '0 : sum_c[k];
                end
                if (s1_last_q) begin
                    saturated <= sat_c;
                    for (int k = 0; k < NUM_FILT; k++) begin
                        out_q[k] <= clamp_c[k];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_filter_dot_product_accumulator.sv
// Directed bench for filter_dot_product_accumulator (FRAC_BITS=8, VECTOR_LENGTH=16).
// A reference model predicts each result and its arrival cycle into a queue;
// a negedge monitor pops and compares whenever result_valid is seen.
module tb_filter_dot_product_accumulator;

    logic        clock;
    logic        clear_n;
    logic        clear;
    logic        en;
    logic        b_elements_ready;
    logic [15:0] a_element;
    logic [15:0] b0_element, b1_element, b2_element, b3_element;
    logic        result_valid;
    logic [15:0] out0, out1, out2, out3;
    logic [3:0]  saturated;
    logic        busy;

    typedef struct {
        int          cyc;
        logic [15:0] o0, o1, o2, o3;
        logic [3:0]  sat;
    } exp_t;

    exp_t   q[$];
    exp_t   held;
    int     cyc;
    int     tests;
    int     fails;
    int     m_cnt;
    longint m_acc [4];

    filter_dot_product_accumulator #(
        .FRAC_BITS    (8),
        .VECTOR_LENGTH(16)
    ) dut (
        .clock           (clock),
        .clear_n         (clear_n),
        .clear           (clear),
        .en              (en),
        .b_elements_ready(b_elements_ready),
        .a_element       (a_element),
        .b0_element      (b0_element),
        .b1_element      (b1_element),
        .b2_element      (b2_element),
        .b3_element      (b3_element),
        .result_valid    (result_valid),
        .out0            (out0),
        .out1            (out1),
        .out2            (out2),
        .out3            (out3),
        .saturated       (saturated),
        .busy            (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Scoreboard monitor: result pulses, their timing, and held outputs
    always @(negedge clock) begin
        if (clear_n) begin
            if (result_valid) begin
                tests++;
                assert (q.size() > 0) else begin
                    fails++;
                    $error("FAIL unexpected_valid: got result_valid=1 at cycle %0d, expected none", cyc);
                end
                if (q.size() > 0) begin
                    held = q.pop_front();
                    tests++;
                    assert (cyc === held.cyc) else begin
                        fails++;
                        $error("FAIL valid_cycle: got %0d, expected %0d", cyc, held.cyc);
                    end
                end
            end else begin
                while (q.size() > 0 && q[0].cyc < cyc) begin
                    tests++;
                    fails++;
                    $error("FAIL missing_valid: got none by cycle %0d, expected at %0d", cyc, q[0].cyc);
                    void'(q.pop_front());
                end
            end
            tests++;
            assert ({out0, out1, out2, out3, saturated} === {held.o0, held.o1, held.o2, held.o3, held.sat}) else begin
                fails++;
                $error("FAIL outputs: got %h %h %h %h sat=%b, expected %h %h %h %h sat=%b",
                       out0, out1, out2, out3, saturated, held.o0, held.o1, held.o2, held.o3, held.sat);
            end
        end
    end

    function automatic logic [15:0] clamp16(input longint s, output logic sat);
        longint sh;
        sh  = s >>> 8;
        sat = 1'b0;
        if (sh > 32767) begin
            sat = 1'b1;
            return 16'h7FFF;
        end else if (sh < -32768) begin
            sat = 1'b1;
            return 16'h8000;
        end
        return 16'(sh);
    endfunction

    // One clock of stimulus; the model predicts the effect of the coming edge
    task automatic step(input logic e, input logic r, input logic c, input logic [15:0] a,
                        input logic [15:0] v0, input logic [15:0] v1,
                        input logic [15:0] v2, input logic [15:0] v3);
        shortint sa;
        shortint sb [4];
        logic    nb;
        logic    s;
        exp_t    x;
        en = e; b_elements_ready = r; clear = c;
        a_element = a; b0_element = v0; b1_element = v1; b2_element = v2; b3_element = v3;
        sa = a; sb[0] = v0; sb[1] = v1; sb[2] = v2; sb[3] = v3;
        if (c) begin
            m_cnt = 0;
            for (int k = 0; k < 4; k++) m_acc[k] = 0;
            while (q.size() > 0 && q[q.size()-1].cyc > cyc) void'(q.pop_back());
            nb = 1'b0;
        end else if (e && r) begin
            for (int k = 0; k < 4; k++) m_acc[k] += longint'(sa) * longint'(sb[k]);
            if (m_cnt == 15) begin
                x.cyc = cyc + 2;
                x.sat = '0;
                x.o0 = clamp16(m_acc[0], s); x.sat[0] = s;
                x.o1 = clamp16(m_acc[1], s); x.sat[1] = s;
                x.o2 = clamp16(m_acc[2], s); x.sat[2] = s;
                x.o3 = clamp16(m_acc[3], s); x.sat[3] = s;
                q.push_back(x);
                m_cnt = 0;
                for (int k = 0; k < 4; k++) m_acc[k] = 0;
            end else begin
                m_cnt++;
            end
            nb = 1'b1;
        end else begin
            nb = (m_cnt != 0);
        end
        @(posedge clock);
        #1;
        tests++;
        assert (busy === nb) else begin
            fails++;
            $error("FAIL busy: got %b, expected %b at cycle %0d", busy, nb, cyc);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    endtask

    task automatic vec16(input logic [15:0] a, input logic [15:0] v0, input logic [15:0] v1);
        for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 1'b0, a, v0, v1, 16'h0, 16'h0);
    endtask

    task automatic chk_out(input string tag, input logic [15:0] e0, input logic [15:0] e1,
                           input logic [15:0] e2, input logic [15:0] e3, input logic [3:0] es);
        tests++;
        assert ({out0, out1, out2, out3, saturated} === {e0, e1, e2, e3, es}) else begin
            fails++;
            $error("FAIL %s: got %h %h %h %h sat=%b, expected %h %h %h %h sat=%b",
                   tag, out0, out1, out2, out3, saturated, e0, e1, e2, e3, es);
        end
    endtask

    task automatic chk_reset(input string tag);
        tests++;
        assert ({result_valid, busy, out0, out1, out2, out3, saturated} === 70'h0) else begin
            fails++;
            $error("FAIL %s: got rv=%b busy=%b %h %h %h %h sat=%b, expected all 0",
                   tag, result_valid, busy, out0, out1, out2, out3, saturated);
        end
    endtask

    task automatic drain_check(input string tag);
        tests++;
        assert (q.size() == 0) else begin
            fails++;
            $error("FAIL %s: got %0d pending results, expected 0", tag, q.size());
        end
    endtask

    initial begin
        tests = 0; fails = 0; cyc = 0; m_cnt = 0;
        for (int k = 0; k < 4; k++) m_acc[k] = 0;
        held = '{cyc: 0, o0: 16'h0, o1: 16'h0, o2: 16'h0, o3: 16'h0, sat: 4'h0};
        clear_n = 1'b0; clear = 1'b0; en = 1'b0; b_elements_ready = 1'b0;
        a_element = '0; b0_element = '0; b1_element = '0; b2_element = '0; b3_element = '0;
        #1;
        chk_reset("reset_state");
        #22;
        clear_n = 1'b1;
        @(posedge clock); #1;

        // Basic vector: 1.0 * 1.0 and 1.0 * -1.0 over 16 elements
        vec16(16'h0100, 16'h0100, 16'hFF00);
        idle(3);
        chk_out("basic", 16'h1000, 16'hF000, 16'h0000, 16'h0000, 4'b0000);
        drain_check("basic_drain");

        // Two back-to-back vectors, pulses 16 cycles apart
        vec16(16'h0100, 16'h0100, 16'hFF00);
        vec16(16'h0100, 16'h0100, 16'hFF00);
        idle(3);
        chk_out("back_to_back", 16'h1000, 16'hF000, 16'h0000, 16'h0000, 4'b0000);
        drain_check("b2b_drain");

        // Gaps in ready and en-low cycles must not disturb accumulation
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b1, 1'b0, 16'h0100, 16'h0100, 16'hFF00, 16'h0, 16'h0);
            if (i % 4 == 3) begin
                for (int j = 0; j < 3; j++) step(1'b1, 1'b0, 1'b0, 16'h7777, 16'h7777, 16'h7777, 16'h7777, 16'h7777);
            end
            if (i == 9) begin
                for (int j = 0; j < 2; j++) step(1'b0, 1'b1, 1'b0, 16'h5555, 16'h5555, 16'h5555, 16'h5555, 16'h5555);
            end
        end
        idle(3);
        chk_out("gapped", 16'h1000, 16'hF000, 16'h0000, 16'h0000, 4'b0000);
        drain_check("gapped_drain");

        // Async reset after 7 accepts, then a fresh vector
        for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 1'b0, 16'h0100, 16'h0100, 16'hFF00, 16'h0, 16'h0);
        #2;
        clear_n = 1'b0;
        m_cnt = 0;
        for (int k = 0; k < 4; k++) m_acc[k] = 0;
        q.delete();
        held = '{cyc: 0, o0: 16'h0, o1: 16'h0, o2: 16'h0, o3: 16'h0, sat: 4'h0};
        #1;
        chk_reset("async_reset_immediate");
        en = 1'b0; b_elements_ready = 1'b0;
        repeat (2) @(posedge clock);
        #3;
        chk_reset("async_reset_held");
        clear_n = 1'b1;
        @(posedge clock); #1;
        vec16(16'h0100, 16'h0100, 16'hFF00);
        idle(3);
        chk_out("after_reset", 16'h1000, 16'hF000, 16'h0000, 16'h0000, 4'b0000);
        drain_check("after_reset_drain");

        // Saturation in both directions
        vec16(16'h7F00, 16'h7F00, 16'h8100);
        idle(3);
        chk_out("saturate", 16'h7FFF, 16'h8000, 16'h0000, 16'h0000, 4'b0011);
        drain_check("saturate_drain");

        // Mixed data on all four filters, including b2/b3
        for (int i = 0; i < 16; i++)
            step(1'b1, 1'b1, 1'b0, 16'(i * 64 - 300), 16'h0180, 16'hFE40, 16'(i * 37), 16'h7FFF);
        idle(3);
        drain_check("mixed_drain");

        // Sync clear with the 5th accept discards the vector; held outputs persist
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 16'h0100, 16'h0100, 16'hFF00, 16'h0, 16'h0);
        step(1'b1, 1'b1, 1'b1, 16'h0100, 16'h0100, 16'hFF00, 16'h0, 16'h0);
        vec16(16'h0100, 16'h0100, 16'hFF00);
        idle(3);
        chk_out("after_clear", 16'h1000, 16'hF000, 16'h0000, 16'h0000, 4'b0000);

        // Sync clear in the cycle after a last accept suppresses that result
        for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 1'b0, 16'h0200, 16'h0200, 16'h0200, 16'h0, 16'h0);
        step(1'b0, 1'b0, 1'b1, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
        idle(4);
        chk_out("clear_suppress", 16'h1000, 16'hF000, 16'h0000, 16'h0000, 4'b0000);
        drain_check("final_drain");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
